// File: rtl/gpio_lease_arbiter.sv
// gpio_lease_arbiter: shares one GPIO bank among NREQ requesters.
// Each requester gets an exclusive, time-limited lease in round-robin order.
// Every change of owner passes through Hi-Z cycles (DRAIN, IDLE, ARM), so two
// owners never drive the pins on consecutive cycles.
//
// Handshake: req_i is a level request. A lease is held while req_i[owner]
// stays high. The owner ends it with a 1-cycle rel_i[owner] strobe or by
// dropping req_i. gnt_o[owner] is high only while the owner's slice drives
// the pins.
module gpio_lease_arbiter #(
  parameter int NREQ    = 4,
  parameter int NPIN    = 34,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          rel_i,
  input  logic [NREQ*NPIN-1:0]     req_out_i,
  input  logic [NREQ*NPIN-1:0]     req_oeb_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [$clog2(NREQ)-1:0]  owner_o,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic [NPIN-1:0]          gpio_out_o,
  output logic [NPIN-1:0]          gpio_oeb_o,
  output logic [1:0]               state_o
);

  localparam int OW = $clog2(NREQ);
  // Lease counter wide enough to reach TIMEOUT-1. With the timeout disabled
  // it stays 1 bit wide and only saturates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_OWN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic [NPIN-1:0] gpio_out_q, gpio_out_d;
  logic [NPIN-1:0] gpio_oeb_q, gpio_oeb_d;

  logic [OW-1:0]   rr_winner;
  logic            rr_found;
  logic [NPIN-1:0] own_out, own_oeb;
  logic            own_rel, own_drop, cnt_hit;

  // Round-robin pick: scan from owner+1 with a wrap at NREQ, first request wins.
  always_comb begin
    int idx;
    idx       = 0;
    rr_winner = owner_q;
    rr_found  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(owner_q) + i) % NREQ;
      if (!rr_found && req_i[idx]) begin
        rr_found  = 1'b1;
        rr_winner = OW'(idx);
      end
    end
  end

  assign own_out  = req_out_i[int'(owner_q)*NPIN +: NPIN];
  assign own_oeb  = req_oeb_i[int'(owner_q)*NPIN +: NPIN];
  assign own_rel  = rel_i[owner_q];
  assign own_drop = !req_i[owner_q];
  // The counter holds the number of completed OWN cycles, so a match on
  // TIMEOUT-1 ends the lease after exactly TIMEOUT OWN cycles.
  assign cnt_hit  = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // Next-state logic. The pins load the owner slice only when the next state
  // is OWN. Every other path sends them to Hi-Z.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    gpio_out_d = '0;
    gpio_oeb_d = '1;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rr_found) begin
            owner_d = rr_winner;
            state_d = ST_ARM;
          end
        end
        ST_ARM: begin
          cnt_d      = '0;
          state_d    = ST_OWN;
          gpio_out_d = own_out;
          gpio_oeb_d = own_oeb;
        end
        ST_OWN: begin
          if (own_rel || own_drop || cnt_hit) begin
            state_d   = ST_DRAIN;
            // A revocation counts as a timeout only when the owner did not
            // leave on its own in the same cycle.
            timeout_d = cnt_hit && !own_rel && !own_drop;
          end else begin
            gpio_out_d = own_out;
            gpio_oeb_d = own_oeb;
            if (cnt_q != {CW{1'b1}}) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and pin registers. Reset puts the pins in Hi-Z at once and gives
  // requester 0 first priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= OW'(NREQ - 1);
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      gpio_out_q <= '0;
      gpio_oeb_q <= '1;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      gpio_out_q <= gpio_out_d;
      gpio_oeb_q <= gpio_oeb_d;
    end
  end

  assign gnt_o      = (state_q == ST_OWN) ? (NREQ'(1) << owner_q) : '0;
  assign owner_o    = owner_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign timeout_o  = timeout_q;
  assign gpio_out_o = gpio_out_q;
  assign gpio_oeb_o = gpio_oeb_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_gpio_lease_arbiter.sv
// Bench for gpio_lease_arbiter. It runs directed scenarios, then random
// traffic. Every cycle is compared against a lease-level reference model.
module tb_gpio_lease_arbiter;

  localparam int NREQ    = 4;
  localparam int NPIN    = 34;
  localparam int TIMEOUT = 8;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic                 en_i;
  logic [NREQ-1:0]      req_i, rel_i;
  logic [NREQ*NPIN-1:0] req_out_i, req_oeb_i;
  logic [NREQ-1:0]      gnt_o;
  logic [1:0]           owner_o;
  logic                 busy_o, timeout_o;
  logic [NPIN-1:0]      gpio_out_o, gpio_oeb_o;
  logic [1:0]           state_o;

  gpio_lease_arbiter #(.NREQ(NREQ), .NPIN(NPIN), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .req_i(req_i), .rel_i(rel_i),
    .req_out_i(req_out_i), .req_oeb_i(req_oeb_i), .gnt_o(gnt_o),
    .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .gpio_out_o(gpio_out_o), .gpio_oeb_o(gpio_oeb_o), .state_o(state_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, in lease terms. holder is -1 when nobody owns the pins.
  // arming marks the one setup cycle before a lease starts. gap marks the
  // Hi-Z cycle after a lease ends.
  int              m_holder, m_last, m_age, m_arming, m_gap;
  logic            m_to;
  logic [NPIN-1:0] m_out, m_oeb;

  function automatic void model_reset();
    m_holder = -1; m_last = NREQ - 1; m_age = 0; m_arming = 0; m_gap = 0;
    m_to = 1'b0; m_out = '0; m_oeb = '1;
  endfunction

  function automatic void model_step();
    bit done;
    if (rst_i) begin
      model_reset();
      return;
    end
    m_to = 1'b0; m_out = '0; m_oeb = '1;
    if (!en_i) begin
      m_holder = -1; m_arming = 0; m_gap = 0;
    end else if (m_holder >= 0) begin
      done = rel_i[m_holder] || !req_i[m_holder] || (TIMEOUT != 0 && m_age + 1 == TIMEOUT);
      if (done) begin
        m_to = (TIMEOUT != 0 && m_age + 1 == TIMEOUT) && !rel_i[m_holder] && req_i[m_holder];
        m_holder = -1; m_gap = 1;
      end else begin
        m_age++;
        m_out = req_out_i[m_holder*NPIN +: NPIN];
        m_oeb = req_oeb_i[m_holder*NPIN +: NPIN];
      end
    end else if (m_arming != 0) begin
      m_arming = 0; m_holder = m_last; m_age = 0;
      m_out = req_out_i[m_last*NPIN +: NPIN];
      m_oeb = req_oeb_i[m_last*NPIN +: NPIN];
    end else if (m_gap != 0) begin
      m_gap = 0;
    end else if (req_i != 0) begin
      for (int i = 1; i <= NREQ; i++) begin
        if (req_i[(m_last + i) % NREQ]) begin
          m_last = (m_last + i) % NREQ;
          break;
        end
      end
      m_arming = 1;
    end
  endfunction

  task automatic compare_all();
    check_eq("gnt", gnt_o, (m_holder >= 0) ? (64'd1 << m_holder) : 64'd0);
    check_eq("owner", owner_o, m_last);
    check_eq("busy", busy_o, (m_holder >= 0 || m_arming != 0 || m_gap != 0));
    check_eq("timeout", timeout_o, m_to);
    check_eq("gpio_out", gpio_out_o, m_out);
    check_eq("gpio_oeb", gpio_oeb_o, m_oeb);
  endtask

  // driver: one clock; inputs change only at the negedge after the compare
  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    compare_all();
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  initial begin
    int own_cnt, hiz_run, gnt_cycles, to_pulses, found;
    bit seen_to;
    logic [NREQ-1:0] prev_gnt;
    en_i = 1'b1; req_i = '0; rel_i = '0; req_out_i = '0; req_oeb_i = '0;
    model_reset();

    // reset then idle
    repeat (2) tick();
    rst_i = 1'b0;
    repeat (10) tick();
    check_eq("idle_oeb", gpio_oeb_o, 34'h3_FFFF_FFFF);
    check_eq("idle_busy", busy_o, 0);

    // round-robin with all requesting, each owner releases after 5 cycles
    req_i = 4'b1111; own_cnt = 0; hiz_run = 0; prev_gnt = '0;
    for (int c = 0; c < 200 && got_q.size() < 5; c++) begin
      rel_i = (gnt_o != 0 && own_cnt == 5) ? gnt_o : '0;
      tick();
      if (gnt_o != 0 && prev_gnt == 0) begin
        got_q.push_back(2'(onehot_idx(gnt_o)));
        if (got_q.size() > 1) check_eq("rr_gap", hiz_run >= 3, 1);
        hiz_run = 0; own_cnt = 0;
      end
      if (gnt_o != 0) own_cnt++;
      else if (gpio_oeb_o == '1) hiz_run++;
      prev_gnt = gnt_o;
    end
    rel_i = '0; req_i = '0;
    repeat (4) tick();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    check_eq("rr_count", got_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size()) check_eq("rr_order", got_q[i], exp_q[i]);

    // single lease on requester 2
    req_i = 4'b0100;
    req_out_i[2*NPIN +: NPIN] = 34'h1234;
    req_oeb_i[2*NPIN +: NPIN] = '0;
    tick();
    check_eq("arm_gnt", gnt_o, 0);
    check_eq("arm_busy", busy_o, 1);
    tick();
    check_eq("own_gnt", gnt_o, 4'b0100);
    check_eq("own_out", gpio_out_o, 34'h1234);
    check_eq("own_oeb", gpio_oeb_o, 0);
    rel_i = 4'b0100;
    tick();
    rel_i = '0; req_i = '0;
    check_eq("drain_oeb", gpio_oeb_o, 34'h3_FFFF_FFFF);
    check_eq("drain_gnt", gnt_o, 0);
    tick();
    check_eq("after_drain_busy", busy_o, 0);

    // timeout on requester 1, then re-grant as sole requester
    req_i = 4'b0010; gnt_cycles = 0; to_pulses = 0; seen_to = 0; found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      tick();
      if (timeout_o) begin
        to_pulses++; seen_to = 1;
        check_eq("to_drain_oeb", gpio_oeb_o, 34'h3_FFFF_FFFF);
      end else if (seen_to && gnt_o[1]) found = 1;
      else if (!seen_to && gnt_o[1]) gnt_cycles++;
    end
    check_eq("to_len", gnt_cycles, TIMEOUT);
    check_eq("to_pulses", to_pulses, 1);
    check_eq("to_regrant", found, 1);
    req_i = '0;
    repeat (3) tick();

    // disable mid-lease with owner 3
    req_i = 4'b1000; found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      tick();
      if (gnt_o == 4'b1000) found = 1;
    end
    check_eq("dis_own", found, 1);
    tick();
    en_i = 1'b0;
    tick();
    check_eq("dis_gnt", gnt_o, 0);
    check_eq("dis_oeb", gpio_oeb_o, 34'h3_FFFF_FFFF);
    check_eq("dis_busy", busy_o, 0);
    check_eq("dis_to", timeout_o, 0);
    en_i = 1'b1;
    tick();
    tick();
    check_eq("dis_regrant", gnt_o, 4'b1000);

    // asynchronous reset between edges during OWN
    @(posedge clk_i);
    model_step();
    #2 rst_i = 1'b1;
    #1;
    check_eq("arst_oeb", gpio_oeb_o, 34'h3_FFFF_FFFF);
    check_eq("arst_gnt", gnt_o, 0);
    model_reset();
    @(negedge clk_i);
    compare_all();
    tick();
    rst_i = 1'b0; req_i = 4'b1001; found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      tick();
      if (gnt_o != 0) found = 1;
    end
    check_eq("arst_first", gnt_o, 4'b0001);
    req_i = '0;
    repeat (3) tick();

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      en_i = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 5) == 0) req_i = NREQ'($urandom_range(0, 15));
      rel_i = ($urandom_range(0, 7) == 0) ? NREQ'($urandom_range(0, 15)) : '0;
      for (int k = 0; k < NREQ; k++) begin
        req_out_i[k*NPIN +: NPIN] = {$urandom, $urandom};
        req_oeb_i[k*NPIN +: NPIN] = {$urandom, $urandom};
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
